// File: rtl/and2_arb.sv
// Four-requester round-robin arbiter sharing a single W-bit AND unit.
// A granted result is held until the consumer accepts it with y_ready.
module and2_arb #(
    parameter int W = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [3:0]     req,
    input  logic [4*W-1:0] a_in,
    input  logic [4*W-1:0] b_in,
    output logic [3:0]     gnt,
    output logic [W-1:0]   y,
    output logic [1:0]     y_id,
    output logic           y_valid,
    input  logic           y_ready,
    output logic           busy,
    output logic [7:0]     txn_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   ptr_q, ptr_d;
    logic [3:0]   gnt_q, gnt_d;
    logic [W-1:0] y_q, y_d;
    logic [1:0]   y_id_q, y_id_d;
    logic         y_valid_q, y_valid_d;
    logic [7:0]   txn_cnt_q, txn_cnt_d;

    // Rotating the doubled request vector puts requester ptr at bit 0.
    logic [7:0]   req_dbl;
    logic [3:0]   rot_req;
    logic [1:0]   win_off;
    logic [1:0]   win_idx;
    logic         any_req;
    logic [3:0]   win_onehot;
    logic [W-1:0] a_masked [4];
    logic [W-1:0] b_masked [4];
    logic [W-1:0] sel_a;
    logic [W-1:0] sel_b;

    assign req_dbl = {req, req};
    assign rot_req = req_dbl[ptr_q +: 4];
    assign any_req = |req;

    always_comb begin
        win_off = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rot_req[i]) begin
                win_off = 2'(i);
            end
        end
    end

    assign win_idx = ptr_q + win_off;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sel
            assign win_onehot[gi] = (win_idx == 2'(gi));
            assign a_masked[gi]   = a_in[gi*W +: W] & {W{win_onehot[gi]}};
            assign b_masked[gi]   = b_in[gi*W +: W] & {W{win_onehot[gi]}};
        end
    endgenerate

    // Operands are muxed first so only one AND unit is needed.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < 4; i++) begin
            sel_a = sel_a | a_masked[i];
            sel_b = sel_b | b_masked[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = 4'b0000;
        y_d       = y_q;
        y_id_d    = y_id_q;
        y_valid_d = y_valid_q;
        txn_cnt_d = txn_cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    y_d       = sel_a & sel_b;
                    y_id_d    = win_idx;
                    y_valid_d = 1'b1;
                    gnt_d     = win_onehot;
                    ptr_d     = win_idx + 2'd1;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (y_ready) begin
                    y_valid_d = 1'b0;
                    txn_cnt_d = txn_cnt_q + 8'd1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            gnt_q     <= 4'b0000;
            y_q       <= '0;
            y_id_q    <= 2'd0;
            y_valid_q <= 1'b0;
            txn_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            y_q       <= y_d;
            y_id_q    <= y_id_d;
            y_valid_q <= y_valid_d;
            txn_cnt_q <= txn_cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign y       = y_q;
    assign y_id    = y_id_q;
    assign y_valid = y_valid_q;
    assign busy    = (state_q == HOLD);
    assign txn_cnt = txn_cnt_q;

endmodule

// File: tb/tb_and2_arb.sv
// Self-checking bench for and2_arb: directed scenarios plus random traffic
// compared against a transaction-level reference model.
module tb_and2_arb;

    localparam int W = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [3:0]     req = '0;
    logic [4*W-1:0] a_in = '0;
    logic [4*W-1:0] b_in = '0;
    logic           y_ready = 1'b0;
    logic [3:0]     gnt;
    logic [W-1:0]   y;
    logic [1:0]     y_id;
    logic           y_valid;
    logic           busy;
    logic [7:0]     txn_cnt;

    int checks = 0;
    int errors = 0;

    and2_arb #(.W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .a_in    (a_in),
        .b_in    (b_in),
        .gnt     (gnt),
        .y       (y),
        .y_id    (y_id),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .busy    (busy),
        .txn_cnt (txn_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: a pending-result queue (at most one entry) and an RR pointer.
    typedef struct {
        logic [W-1:0] val;
        int           id;
    } result_t;

    result_t      pend[$];
    int           m_ptr;
    int           m_cnt;
    logic [3:0]   m_gnt;
    logic [W-1:0] m_y;
    int           m_id;
    string        cur_tag = "init";

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        m_ptr = 0;
        m_cnt = 0;
        m_gnt = '0;
        m_y   = '0;
        m_id  = 0;
    endtask

    task automatic model_edge();
        result_t r;
        int k;
        m_gnt = '0;
        if (pend.size() == 0) begin
            if (req != 0) begin
                k = -1;
                for (int j = 0; j < 4; j++) begin
                    if (k < 0 && req[(m_ptr + j) % 4]) k = (m_ptr + j) % 4;
                end
                r.val = a_in[k*W +: W] & b_in[k*W +: W];
                r.id  = k;
                pend.push_back(r);
                m_y   = r.val;
                m_id  = k;
                m_gnt = 4'(1 << k);
                m_ptr = (k + 1) % 4;
            end
        end else if (y_ready) begin
            void'(pend.pop_front());
            m_cnt = (m_cnt + 1) % 256;
        end
    endtask

    task automatic check_all();
        chk({cur_tag, ".gnt"},     32'(gnt),     32'(m_gnt));
        chk({cur_tag, ".y"},       32'(y),       32'(m_y));
        chk({cur_tag, ".y_id"},    32'(y_id),    32'(m_id));
        chk({cur_tag, ".y_valid"}, 32'(y_valid), 32'(pend.size() != 0));
        chk({cur_tag, ".busy"},    32'(busy),    32'(pend.size() != 0));
        chk({cur_tag, ".txn_cnt"}, 32'(txn_cnt), 32'(m_cnt));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst.gnt",     32'(gnt),     32'd0);
        chk("rst.y",       32'(y),       32'd0);
        chk("rst.y_id",    32'(y_id),    32'd0);
        chk("rst.y_valid", 32'(y_valid), 32'd0);
        chk("rst.busy",    32'(busy),    32'd0);
        chk("rst.txn_cnt", 32'(txn_cnt), 32'd0);
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        a_in[i*W +: W] = a;
        b_in[i*W +: W] = b;
    endtask

    int last_k;
    int k_now;

    initial begin
        model_reset();
        #3;
        do_reset();

        // Single request
        cur_tag = "single";
        req = 4'b0001; set_ops(0, 2'b00, 2'b01); y_ready = 1'b1;
        step();
        chk("single.gnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        step();
        chk("single.gnt_off", 32'(gnt), 32'h0);
        chk("single.cnt", 32'(txn_cnt), 32'd1);

        // All requesting, each drops on its grant
        do_reset();
        cur_tag = "all";
        req = 4'b1111; y_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_ops(i, 2'b10, 2'b10);
        for (int n = 0; n < 8; n++) begin
            step();
            if (gnt != 0) begin
                chk("all.order", 32'(y_id), 32'(n / 2));
                chk("all.y", 32'(y), 32'h2);
            end
            req = req & ~gnt;
        end
        chk("all.cnt", 32'(txn_cnt), 32'd4);

        // Fairness with requesters 0 and 2 always asking
        cur_tag = "fair";
        req = 4'b0101; last_k = 2;
        for (int n = 0; n < 10; n++) begin
            step();
            if (gnt != 0) begin
                k_now = (gnt == 4'b0001) ? 0 : (gnt == 4'b0100) ? 2 : -1;
                chk("fair.alt", 32'(k_now), 32'((last_k == 0) ? 2 : 0));
                last_k = k_now;
            end
        end

        // Backpressure on requester 3, operands and requests churn during HOLD
        do_reset();
        cur_tag = "bp";
        req = 4'b1000; set_ops(3, 2'b11, 2'b01); y_ready = 1'b0;
        step();
        chk("bp.gnt", 32'(gnt), 32'h8);
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            set_ops(3, W'($urandom), W'($urandom));
            step();
            chk("bp.y", 32'(y), 32'h1);
            chk("bp.y_id", 32'(y_id), 32'd3);
            chk("bp.valid", 32'(y_valid), 32'd1);
            chk("bp.no_gnt", 32'(gnt), 32'h0);
        end
        req = 4'b0000; y_ready = 1'b1;
        step();
        chk("bp.accept", 32'(y_valid), 32'd0);
        chk("bp.cnt", 32'(txn_cnt), 32'd1);

        // Reset while a result is pending
        do_reset();
        cur_tag = "rsthold";
        req = 4'b0010; y_ready = 1'b0;
        step();
        chk("rsthold.valid", 32'(y_valid), 32'd1);
        do_reset();
        req = 4'b1111;
        step();
        chk("rsthold.first", 32'(gnt), 32'h1);

        // Random traffic against the model
        do_reset();
        cur_tag = "rand";
        for (int n = 0; n < 400; n++) begin
            req     = 4'($urandom_range(0, 15));
            a_in    = (4*W)'($urandom);
            b_in    = (4*W)'($urandom);
            y_ready = 1'($urandom_range(0, 1));
            step();
        end

        // 256 accepted transactions wrap the counter
        do_reset();
        cur_tag = "wrap";
        req = 4'b1111; y_ready = 1'b1;
        for (int n = 0; n < 512; n++) begin
            a_in = (4*W)'($urandom);
            b_in = (4*W)'($urandom);
            step();
            if (n == 509) chk("wrap.255", 32'(txn_cnt), 32'd255);
        end
        chk("wrap.zero", 32'(txn_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
